wb_stream_master: RTL and testbench

//  Wishbone classic bus initiator driven by a byte-stream command channel (e.g. the USB serial

---
 rtl/wb_stream_master.sv | 175 +++++++++++++++++
 tb/tb_wb_stream_master.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_master.sv
// rtl/wb_stream_master.sv - byte-stream command decoder driving one single-beat Wishbone classic cycle per packet
// Optional WB_STREAM_MASTER_AUTOINC_EN adds WRITE-NEXT (0x11) / READ-NEXT (0x12) commands.
module wb_stream_master #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_reset_ni,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    output logic          rx_ready_o,
    output logic [7:0]    tx_data_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    output logic          busy_o
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP} state_t;

    state_t        r_state, w_next;
    logic [1:0]    r_cnt;
    logic [23:0]   r_shift;
    logic          r_we;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_dat;
    logic [DW-1:0] r_rdata;
    logic [7:0]    r_code;
    logic [2:0]    r_tx_idx;
    logic [2:0]    r_tx_last;
    logic [15:0]   r_timer;
`ifdef WB_STREAM_MASTER_AUTOINC_EN
    logic          r_adr_vld;
`endif
    logic          w_rx_fire;
    logic          w_tx_fire;
    logic          w_term;
    logic [7:0]    w_tx_data;

    assign rx_ready_o = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_WDATA);
    assign tx_valid_o = (r_state == S_RESP);
    assign tx_data_o  = w_tx_data;
    assign wb_cyc_o   = (r_state == S_BUS);
    assign wb_stb_o   = wb_cyc_o;
    assign wb_we_o    = wb_cyc_o & r_we;
    assign wb_sel_o   = wb_cyc_o ? 4'hF : 4'h0;
    assign wb_adr_o   = r_adr;
    assign wb_dat_o   = r_dat;
    assign busy_o     = (r_state != S_IDLE);
    assign w_rx_fire  = rx_valid_i & rx_ready_o;
    assign w_tx_fire  = tx_valid_o & tx_ready_i;
    assign w_term     = wb_err_i | wb_ack_i | (r_timer == 16'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_rx_fire) begin
                case (rx_data_i)
                    8'h01, 8'h02: w_next = S_ADDR;
`ifdef WB_STREAM_MASTER_AUTOINC_EN
                    8'h11:        w_next = S_WDATA;
                    8'h12:        w_next = S_BUS;
`endif
                    default:      w_next = S_RESP;
                endcase
            end
            S_ADDR:  if (w_rx_fire && r_cnt == 2'd3) w_next = r_we ? S_WDATA : S_BUS;
            S_WDATA: if (w_rx_fire && r_cnt == 2'd3) w_next = S_BUS;
            S_BUS:   if (w_term) w_next = S_RESP;
            S_RESP:  if (w_tx_fire && r_tx_idx == r_tx_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_data = 8'h00;
        if (r_state == S_RESP) begin
            case (r_tx_idx)
                3'd0:    w_tx_data = r_code;
                3'd1:    w_tx_data = r_rdata[31:24];
                3'd2:    w_tx_data = r_rdata[23:16];
                3'd3:    w_tx_data = r_rdata[15:8];
                default: w_tx_data = r_rdata[7:0];
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            r_cnt     <= 2'd0;
            r_shift   <= 24'd0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_rdata   <= '0;
            r_code    <= 8'h00;
            r_tx_idx  <= 3'd0;
            r_tx_last <= 3'd0;
            r_timer   <= 16'd0;
`ifdef WB_STREAM_MASTER_AUTOINC_EN
            r_adr_vld <= 1'b0;
`endif
        end else begin
            if (w_next == S_BUS && r_state != S_BUS) begin
                r_timer <= 16'(TIMEOUT);
            end
            case (r_state)
                S_IDLE: if (w_rx_fire) begin
                    r_cnt     <= 2'd0;
                    r_we      <= (rx_data_i == 8'h01) || (rx_data_i == 8'h11);
                    r_code    <= 8'hEF;
                    r_tx_idx  <= 3'd0;
                    r_tx_last <= 3'd0;
`ifdef WB_STREAM_MASTER_AUTOINC_EN
                    // Until an addressed command has run, the "next" address is 0
                    if (rx_data_i == 8'h11 || rx_data_i == 8'h12) begin
                        r_adr     <= r_adr_vld ? r_adr + AW'(1) : '0;
                        r_adr_vld <= 1'b1;
                    end
`endif
                end
                S_ADDR: if (w_rx_fire) begin
                    r_shift <= {r_shift[15:0], rx_data_i};
                    r_cnt   <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_adr <= AW'({r_shift, rx_data_i[7:2]});
`ifdef WB_STREAM_MASTER_AUTOINC_EN
                        r_adr_vld <= 1'b1;
`endif
                    end
                end
                S_WDATA: if (w_rx_fire) begin
                    r_shift <= {r_shift[15:0], rx_data_i};
                    r_cnt   <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) r_dat <= {r_shift, rx_data_i};
                end
                S_BUS: begin
                    r_tx_idx  <= 3'd0;
                    r_tx_last <= 3'd0;
                    if (wb_err_i) begin
                        r_code <= r_we ? 8'hE1 : 8'hE2;
                    end else if (wb_ack_i) begin
                        r_code <= r_we ? 8'h81 : 8'h82;
                        if (!r_we) begin
                            r_rdata   <= wb_dat_i;
                            r_tx_last <= 3'd4;
                        end
                    end else if (r_timer == 16'd0) begin
                        r_code <= 8'hEE;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_RESP: if (w_tx_fire) r_tx_idx <= r_tx_idx + 3'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_stream_master.sv
// tb/tb_wb_stream_master.sv - directed self-checking bench for wb_stream_master (TIMEOUT=16)
module tb_wb_stream_master;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          cyc, stb, we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_o;
    logic [3:0]    sel;
    logic [DW-1:0] dat_i = '0;
    logic          ack = 1'b0;
    logic          err = 1'b0;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_seen = 0;
    int cyc_cnt;
    int nrx;
    logic [7:0]    rb [0:4];
    logic [AW-1:0] bus_adr;
    logic [DW-1:0] bus_dat;
    logic          bus_we;
    logic [3:0]    bus_sel;

    wb_stream_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_reset_ni(rst_n),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
        .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_dat_i(dat_i),
        .wb_ack_i(ack), .wb_err_i(err), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (cyc) cyc_seen <= cyc_seen + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        rx_valid = 1'b1;
        rx_data  = b;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        if (k == 100) chk("rx_accept_timeout", 0, 1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Slave: terminates on the (after+1)-th cyc cycle; counts cycles cyc stays high
    task automatic run_bus(input int after, input logic do_ack, input logic do_err, input logic [31:0] rd);
        cyc_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (!cyc) break;
            if (cyc_cnt == 0) begin
                bus_adr = adr; bus_dat = dat_o; bus_we = we; bus_sel = sel;
            end
            cyc_cnt++;
            if (cyc_cnt == after + 1) begin
                ack = do_ack; err = do_err; dat_i = rd;
            end
            @(posedge clk); #1;
            ack = 1'b0; err = 1'b0;
        end
    endtask

    task automatic recv(input int n, input int stall, input logic [7:0] exp0);
        tx_ready = 1'b0;
        if (stall > 0) begin
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, exp0);
                chk("stall_rx_ready", rx_ready, 0);
            end
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        nrx = 0;
        for (int k = 0; k < 200 && nrx < n; k++) begin
            @(negedge clk);
            if (tx_valid) begin
                rb[nrx] = tx_data;
                nrx++;
            end
        end
        chk("resp_count", nrx, n);
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_cyc", {cyc, stb, we}, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Write with ack after 2 wait cycles
        send(8'h01); send(8'h10); send(8'h00); send(8'h00); send(8'h08);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        chk("wr_rx_ready_bus", rx_ready, 0);
        run_bus(2, 1'b1, 1'b0, 32'h0);
        chk("wr_adr", bus_adr, 30'h04000002);
        chk("wr_dat", bus_dat, 32'hDEADBEEF);
        chk("wr_we", bus_we, 1);
        chk("wr_sel", bus_sel, 4'hF);
        chk("wr_cyc_cycles", cyc_cnt, 3);
        recv(1, 0, 8'h81);
        chk("wr_resp", rb[0], 8'h81);
        chk("wr_idle_busy", busy, 0);
        chk("wr_adr_hold", adr, 30'h04000002);

        // Read with 10-cycle tx stall
        send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h04);
        run_bus(0, 1'b1, 1'b0, 32'h12345678);
        chk("rd_adr", bus_adr, 30'h1);
        chk("rd_we", bus_we, 0);
        recv(5, 10, 8'h82);
        chk("rd_resp", {rb[0], rb[1], rb[2], rb[3], rb[4]}, 40'h8212345678);

        // Timeout: cyc high TIMEOUT+1 cycles
        send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h20);
        run_bus(1000, 1'b0, 1'b0, 32'h0);
        chk("to_cyc_cycles", cyc_cnt, TO + 1);
        chk("to_cyc_low", cyc, 0);
        recv(1, 0, 8'hEE);
        chk("to_resp", rb[0], 8'hEE);

        // ack+err together: err wins
        send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h10);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        run_bus(0, 1'b1, 1'b1, 32'h0);
        recv(1, 0, 8'hE1);
        chk("err_wr_resp", rb[0], 8'hE1);
        send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h10);
        run_bus(1, 1'b1, 1'b1, 32'hCAFEF00D);
        recv(1, 0, 8'hE2);
        chk("err_rd_resp", rb[0], 8'hE2);

        // Unknown command
        cyc_seen = 0;
        send(8'h55);
        recv(1, 0, 8'hEF);
        chk("unk_resp", rb[0], 8'hEF);
        chk("unk_no_cyc", cyc_seen, 0);

`ifdef WB_STREAM_MASTER_AUTOINC_EN
        send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'hFC);
        run_bus(0, 1'b1, 1'b0, 32'h0);
        chk("ai_adr0", bus_adr, 30'h3F);
        recv(5, 0, 8'h82);
        send(8'h12);
        run_bus(0, 1'b1, 1'b0, 32'h0);
        chk("ai_adr1", bus_adr, 30'h40);
        recv(5, 0, 8'h82);
        send(8'h12);
        run_bus(0, 1'b1, 1'b0, 32'h0);
        chk("ai_adr2", bus_adr, 30'h41);
        recv(5, 0, 8'h82);
`else
        cyc_seen = 0;
        send(8'h12);
        recv(1, 0, 8'hEF);
        chk("noai_12_resp", rb[0], 8'hEF);
        send(8'h11);
        recv(1, 0, 8'hEF);
        chk("noai_11_resp", rb[0], 8'hEF);
        chk("noai_no_cyc", cyc_seen, 0);
`endif

        // Reset during BUS drops cyc immediately
        send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h08);
        chk("rst_bus_cyc_before", cyc, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bus_cyc", cyc, 0);
        chk("rst_bus_busy", busy, 0);
        chk("rst_bus_rx_ready", rx_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_bus_idle_after", {busy, cyc, tx_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
